dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
- Responder on the core's data-memory port: answers the memory-stage write strobe, address, write data and read data.
- Contains a word-addressed data RAM.
- Also contains a small memory-mapped peripheral space: LED register, free-running cycle counter, one-shot/auto-reload timer with a sticky expiry flag.
- Sits beside the processor top-level in the system wrapper; read data is returned combinationally in the same cycle to meet memory-stage timing.

Parameters:
AW, 6, RAM word-address width; RAM holds 2^AW 32-bit words
LED_W, 8, width of LED output register

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
we  in  1  write strobe for current address (memory stage)
a  in  32  byte address from ALU result
wd  in  32  write data
rd  out  32  read data, combinational from a and current state
led  out  LED_W  LED register contents
timer_irq  out  1  level copy of timer expired flag

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Address decode:
  - a[31]=0 selects RAM, index a[AW+1:2]. Upper bits a[30:AW+2] are ignored, so addresses alias (wrap) modulo 2^AW words.
  - a[31]=1 selects MMIO, offset a[4:2]; a[30:5] are ignored.
  - a[1:0] are ignored everywhere; no byte or halfword access.
- RAM:
  - Write on rising edge when we=1.
  - Read is asynchronous from the current array.
  - A read in the same cycle as a write to the same word returns the old value; the new value is visible next cycle.
  - RAM contents are not cleared by reset.
- MMIO map (byte offsets from 0x8000_0000):
  - 0x00 LED: RW, LED_W bits, zero-extended on read.
  - 0x04 CYCLE: RO, 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF to 0; writes ignored.
  - 0x08 TCMP: RW, 32-bit compare value. Any write also forces TCOUNT to 0 that cycle.
  - 0x0C TCTRL: RW, bit0 EN, bit1 AUTO; other bits read 0.
  - 0x10 TSTAT: bit0 EXP (sticky). Write 1 to bit0 clears it; writing 0 has no effect.
  - 0x14 TCOUNT: RO, 32-bit timer count.
  - 0x18 and 0x1C: read 0, writes ignored.
- Timer, evaluated each cycle when EN=1:
  - If TCOUNT==TCMP: EXP<=1.
    - AUTO=1: TCOUNT<=0, EN stays 1.
    - AUTO=0: TCOUNT holds, EN<=0.
  - Otherwise TCOUNT<=TCOUNT+1, wrapping modulo 2^32.
  - EN=0: TCOUNT holds.
- Simultaneous events:
  - Expiry set and W1C clear in the same cycle: set wins, EXP=1.
  - Write to TCTRL in the same cycle as a one-shot expiry: the written EN value wins, but EXP still sets.
  - Write to TCMP in the same cycle as a match: TCOUNT<=0 and EXP still sets from the pre-write comparison.
  - TCMP=0 with EN=1: expires on the first enabled cycle.
- timer_irq = EXP, with no extra latency beyond the register.
- Reset values: LED=0, CYCLE=0, TCMP=0, TCTRL=0, TSTAT=0, TCOUNT=0, led=0, timer_irq=0.
  - rd while in reset reflects the reset-value registers for MMIO and the current array for RAM.
- Reset mid-operation: all MMIO state returns to reset values on the next edge; an in-flight write with reset=1 is dropped for MMIO but still lands in RAM.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and alias 0x0000_0110 (AW=6) -> both read 0xDEADBEEF. Same-cycle read during the write -> old value.
- Write 0x1A5 to 0x8000_0000 -> led=0xA5 next cycle, rd=0x0000_00A5. Reset -> led=0.
- Release reset, wait 10 cycles, read 0x8000_0004 -> 10 (±1 per the sampling edge, fixed in the bench). Write 0 to CYCLE -> value unaffected.
- TCMP=3, TCTRL=1 (one-shot) -> TCOUNT steps 0,1,2,3. timer_irq=1 on the cycle after TCOUNT reads 3; TCTRL reads 0; TCOUNT holds 3.
- TCMP=2, TCTRL=3 (auto-reload), clear EXP via write 1 to 0x8000_0010 timed on a match cycle -> EXP remains 1 (set wins). Next clear off-match -> EXP=0, and it reasserts 3 cycles later.
- Read 0x8000_0018 -> 0. Write 1 to TSTAT bit0 while EXP=0 -> no change. Assert reset with timer running -> all MMIO reads 0, timer_irq=0.

Source files
------------

// File: rtl/dmem_mmio.sv
// ============================================================================
// Module  : dmem_mmio
// Brief   : Data-memory responder: word RAM plus LED, cycle counter and timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_mmio #(
  parameter int AW    = 6,
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [31:0]      a,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  output logic [LED_W-1:0] led,
  output logic             timer_irq
);

  localparam logic [2:0] C_OFF_LED    = 3'd0;
  localparam logic [2:0] C_OFF_CYCLE  = 3'd1;
  localparam logic [2:0] C_OFF_TCMP   = 3'd2;
  localparam logic [2:0] C_OFF_TCTRL  = 3'd3;
  localparam logic [2:0] C_OFF_TSTAT  = 3'd4;
  localparam logic [2:0] C_OFF_TCOUNT = 3'd5;

  logic [31:0]      r_mem [2**AW];
  logic [LED_W-1:0] r_led;
  logic [31:0]      r_cycle;
  logic [31:0]      r_tcmp;
  logic [31:0]      r_tcount;
  logic             r_en;
  logic             r_auto;
  logic             r_exp;

  logic [AW-1:0] w_ramIdx;
  logic [2:0]    w_off;
  logic          w_ramWe;
  logic          w_mmioWe;
  logic          w_wrLed;
  logic          w_wrTcmp;
  logic          w_wrTctrl;
  logic          w_wrTstat;
  logic          w_match;
  logic          w_unused;

  assign w_ramIdx  = a[AW+1:2];
  assign w_off     = a[4:2];
  assign w_ramWe   = we & ~a[31];
  assign w_mmioWe  = we & a[31];
  assign w_wrLed   = w_mmioWe && (w_off == C_OFF_LED);
  assign w_wrTcmp  = w_mmioWe && (w_off == C_OFF_TCMP);
  assign w_wrTctrl = w_mmioWe && (w_off == C_OFF_TCTRL);
  assign w_wrTstat = w_mmioWe && (w_off == C_OFF_TSTAT);
  assign w_match   = r_en && (r_tcount == r_tcmp);
  assign w_unused  = &{1'b0, a[30:AW+2], a[1:0]};

  // RAM ignores reset so that stores issued during reset still land.
  always_ff @(posedge clk) begin
    if (w_ramWe) begin
      r_mem[w_ramIdx] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led    <= '0;
      r_cycle  <= '0;
      r_tcmp   <= '0;
      r_tcount <= '0;
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_exp    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;

      if (w_wrLed) begin
        r_led <= wd[LED_W-1:0];
      end
      if (w_wrTcmp) begin
        r_tcmp <= wd;
      end

      // A TCMP write restarts the count even when it coincides with a match.
      if (w_wrTcmp) begin
        r_tcount <= '0;
      end else if (r_en) begin
        if (w_match) begin
          if (r_auto) begin
            r_tcount <= '0;
          end
        end else begin
          r_tcount <= r_tcount + 32'd1;
        end
      end

      if (w_wrTctrl) begin
        r_en   <= wd[0];
        r_auto <= wd[1];
      end else if (w_match && !r_auto) begin
        r_en <= 1'b0;
      end

      // Expiry takes priority over a simultaneous write-one-to-clear.
      if (w_match) begin
        r_exp <= 1'b1;
      end else if (w_wrTstat && wd[0]) begin
        r_exp <= 1'b0;
      end
    end
  end

  always_comb begin
    rd = 32'd0;
    if (a[31]) begin
      case (w_off)
        C_OFF_LED:    rd = 32'(r_led);
        C_OFF_CYCLE:  rd = r_cycle;
        C_OFF_TCMP:   rd = r_tcmp;
        C_OFF_TCTRL:  rd = {30'd0, r_auto, r_en};
        C_OFF_TSTAT:  rd = {31'd0, r_exp};
        C_OFF_TCOUNT: rd = r_tcount;
        default:      rd = 32'd0;
      endcase
    end else begin
      rd = r_mem[w_ramIdx];
    end
  end

  assign led       = r_led;
  assign timer_irq = r_exp;

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio.sv
// ============================================================================
// Module  : tb_dmem_mmio
// Brief   : Directed self-checking bench for dmem_mmio.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_mmio;

  localparam logic [31:0] C_LED    = 32'h8000_0000;
  localparam logic [31:0] C_CYCLE  = 32'h8000_0004;
  localparam logic [31:0] C_TCMP   = 32'h8000_0008;
  localparam logic [31:0] C_TCTRL  = 32'h8000_000C;
  localparam logic [31:0] C_TSTAT  = 32'h8000_0010;
  localparam logic [31:0] C_TCOUNT = 32'h8000_0014;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [7:0]  led;
  logic        timer_irq;

  int checks;
  int failures;

  dmem_mmio #(.AW(6), .LED_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .a         (a),
    .wd        (wd),
    .rd        (rd),
    .led       (led),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic writeBus(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    step();
    we = 1'b0;
  endtask

  task automatic readChk(input string tag, input logic [31:0] addr, input logic [31:0] expv);
    we = 1'b0;
    a  = addr;
    #1;
    chk(tag, rd, expv);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    we       = 1'b0;
    a        = 32'd0;
    wd       = 32'd0;
    step();
    step();

    // Reset state
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_irq", 32'(timer_irq), 32'd0);
    readChk("rst_cycle", C_CYCLE, 32'd0);
    readChk("rst_tcount", C_TCOUNT, 32'd0);

    // Cycle counter
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    readChk("cycle_10", C_CYCLE, 32'd10);
    writeBus(C_CYCLE, 32'd0);
    readChk("cycle_ro", C_CYCLE, 32'd11);

    // RAM, aliasing and same-cycle read-during-write
    writeBus(32'h0000_0010, 32'h1111_1111);
    writeBus(32'h0000_0014, 32'h2222_2222);
    we = 1'b1;
    a  = 32'h0000_0010;
    wd = 32'hDEAD_BEEF;
    #1;
    chk("ram_rdw_old", rd, 32'h1111_1111);
    step();
    we = 1'b0;
    readChk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    readChk("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    readChk("ram_other", 32'h0000_0014, 32'h2222_2222);

    // LED register
    writeBus(C_LED, 32'h0000_01A5);
    chk("led_port", 32'(led), 32'h0000_00A5);
    readChk("led_rd", C_LED, 32'h0000_00A5);

    // One-shot timer
    writeBus(C_TCMP, 32'd3);
    writeBus(C_TCTRL, 32'd1);
    readChk("os_tc0", C_TCOUNT, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      readChk("os_tc", C_TCOUNT, 32'(i));
      chk("os_irq_lo", 32'(timer_irq), 32'd0);
    end
    step();
    chk("os_irq_hi", 32'(timer_irq), 32'd1);
    readChk("os_tctrl", C_TCTRL, 32'd0);
    readChk("os_hold", C_TCOUNT, 32'd3);
    readChk("os_tstat", C_TSTAT, 32'd1);
    step();
    readChk("os_hold2", C_TCOUNT, 32'd3);
    writeBus(C_TSTAT, 32'd0);
    chk("w0_noclr", 32'(timer_irq), 32'd1);
    writeBus(C_TSTAT, 32'd1);
    chk("w1c", 32'(timer_irq), 32'd0);

    // Auto-reload timer, clear colliding with match
    writeBus(C_TCMP, 32'd2);
    writeBus(C_TCTRL, 32'd3);
    readChk("ar_tc0", C_TCOUNT, 32'd0);
    step();
    readChk("ar_tc1", C_TCOUNT, 32'd1);
    step();
    readChk("ar_tc2", C_TCOUNT, 32'd2);
    chk("ar_irq_lo", 32'(timer_irq), 32'd0);
    step();
    chk("ar_irq_hi", 32'(timer_irq), 32'd1);
    readChk("ar_reload", C_TCOUNT, 32'd0);
    step();
    step();
    readChk("ar_tc2b", C_TCOUNT, 32'd2);
    writeBus(C_TSTAT, 32'd1);
    chk("set_wins", 32'(timer_irq), 32'd1);
    readChk("ar_reload2", C_TCOUNT, 32'd0);
    writeBus(C_TSTAT, 32'd1);
    chk("ar_clr", 32'(timer_irq), 32'd0);
    step();
    chk("ar_irq_wait", 32'(timer_irq), 32'd0);
    step();
    chk("ar_reassert", 32'(timer_irq), 32'd1);
    readChk("unused18", 32'h8000_0018, 32'd0);
    readChk("unused1c", 32'h8000_001C, 32'd0);
    readChk("ar_tctrl", C_TCTRL, 32'd3);

    // W1C on clear flag, then TCMP write on a match cycle
    writeBus(C_TSTAT, 32'd1);
    writeBus(C_TSTAT, 32'd1);
    chk("w1_exp0", 32'(timer_irq), 32'd0);
    readChk("pre_tcmp_tc", C_TCOUNT, 32'd2);
    writeBus(C_TCMP, 32'd5);
    chk("tcmp_match_exp", 32'(timer_irq), 32'd1);
    readChk("tcmp_match_tc", C_TCOUNT, 32'd0);
    readChk("tcmp_val", C_TCMP, 32'd5);

    // Reset with timer running and writes in flight
    reset = 1'b1;
    we    = 1'b1;
    a     = C_LED;
    wd    = 32'h0000_00FF;
    step();
    a     = 32'h0000_0020;
    wd    = 32'h5A5A_5A5A;
    step();
    we    = 1'b0;
    chk("mrst_led", 32'(led), 32'd0);
    chk("mrst_irq", 32'(timer_irq), 32'd0);
    readChk("mrst_tcount", C_TCOUNT, 32'd0);
    readChk("mrst_tcmp", C_TCMP, 32'd0);
    readChk("mrst_tctrl", C_TCTRL, 32'd0);
    readChk("mrst_tstat", C_TSTAT, 32'd0);
    readChk("mrst_cycle", C_CYCLE, 32'd0);
    readChk("mrst_ram", 32'h0000_0020, 32'h5A5A_5A5A);
    reset = 1'b0;
    step();
    readChk("post_cycle", C_CYCLE, 32'd1);
    readChk("post_tcount", C_TCOUNT, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
